// File: rtl/arbiter_rr2_if.sv
// rtl/arbiter_rr2_if.sv - request/grant bundle between two requesters and arbiter_rr2
//
// Signals:
//   req0, req1 : level-held requests from requesters 0 and 1
//   gnt0, gnt1 : registered, mutually exclusive grants
//   preempt    : one-cycle pulse when a grant is moved by hold-limit expiry
// Modports:
//   master : requester side (drives requests, observes grants)
//   slave  : arbiter side (observes requests, drives grants)
interface arbiter_rr2_if;
  logic req0;
  logic req1;
  logic gnt0;
  logic gnt1;
  logic preempt;

  modport master (
    output req0,
    output req1,
    input  gnt0,
    input  gnt1,
    input  preempt
  );

  modport slave (
    input  req0,
    input  req1,
    output gnt0,
    output gnt1,
    output preempt
  );
endinterface

// File: rtl/arbiter_rr2.sv
// rtl/arbiter_rr2.sv - two-requester bus arbiter with hold-limit pre-emption
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : arbiter_rr2_if.slave (req0/req1 in, gnt0/gnt1/preempt out)
// Parameters:
//   MAX_HOLD : grant cycles allowed while the other side waits (0 = no pre-emption)
//   CNT_W    : hold counter width, 2**CNT_W > MAX_HOLD
// Build option:
//   ARB_ROUND_ROBIN_EN defined   -> ties in IDLE alternate (first tie to requester 0)
//   ARB_ROUND_ROBIN_EN undefined -> ties in IDLE always go to requester 0
module arbiter_rr2 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic         clk,
  input  logic         reset,
  arbiter_rr2_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  // Saturation point of the hold counter; pre-emption fires when it is reached.
  localparam logic [CNT_W-1:0] HOLD_LAST  = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic             PREEMPT_EN = (MAX_HOLD != 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             preempt_q, preempt_nxt;
  logic             tie_to1;

`ifdef ARB_ROUND_ROBIN_EN
  // Last requester granted; reset value 1 makes the first tie go to requester 0.
  logic last, last_nxt;

  always_comb begin
    tie_to1 = ~last;
  end

  always_comb begin
    last_nxt = last;
    if (state_nxt == GNT0 && state != GNT0) last_nxt = 1'b0;
    if (state_nxt == GNT1 && state != GNT1) last_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last <= 1'b1;
    else       last <= last_nxt;
  end
`else
  always_comb begin
    tie_to1 = 1'b0;
  end
`endif

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = '0;       // cleared on every entry and while idle
    preempt_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) state_nxt = tie_to1 ? GNT1 : GNT0;
        else if (bus.req0)        state_nxt = GNT0;
        else if (bus.req1)        state_nxt = GNT1;
      end
      GNT0: begin
        if (!bus.req0) begin
          state_nxt = bus.req1 ? GNT1 : IDLE;
        end else if (bus.req1 && PREEMPT_EN && hold_cnt == HOLD_LAST) begin
          state_nxt   = GNT1;
          preempt_nxt = 1'b1;
        end else begin
          hold_cnt_nxt = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
        end
      end
      GNT1: begin
        if (!bus.req1) begin
          state_nxt = bus.req0 ? GNT0 : IDLE;
        end else if (bus.req0 && PREEMPT_EN && hold_cnt == HOLD_LAST) begin
          state_nxt   = GNT0;
          preempt_nxt = 1'b1;
        end else begin
          hold_cnt_nxt = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      preempt_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      preempt_q <= preempt_nxt;
    end
  end

  assign bus.gnt0    = (state == GNT0);
  assign bus.gnt1    = (state == GNT1);
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_arbiter_rr2.sv
// tb/tb_arbiter_rr2.sv - self-checking bench for arbiter_rr2
module tb_arbiter_rr2;
  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  arbiter_rr2_if bus ();

  arbiter_rr2 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: owner (-1 none), cycles owned so far, last winner.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 1;
  int m_pre   = 0;

  function automatic void model_reset();
    m_owner = -1; m_held = 0; m_last = 1; m_pre = 0;
  endfunction

  function automatic void model_grant(input int w);
    m_owner = w; m_held = 1; m_last = w;
  endfunction

  function automatic void model_edge(input bit r0, input bit r1);
    bit r[2];
    int x, y, w;
    r[0] = r0; r[1] = r1;
    m_pre = 0;
    if (m_owner < 0) begin
      if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
        w = 1 - m_last;
`else
        w = 0;
`endif
        model_grant(w);
      end else if (r0) model_grant(0);
      else if (r1)     model_grant(1);
    end else begin
      x = m_owner; y = 1 - x;
      if (!r[x]) begin
        if (r[y]) model_grant(y);
        else      m_owner = -1;
      end else if (r[y] && MAX_HOLD != 0 && m_held >= MAX_HOLD) begin
        model_grant(y);
        m_pre = 1;
      end else begin
        m_held++;
      end
    end
  endfunction

  task automatic step(input bit r0, input bit r1, input string tag);
    @(negedge clk);
    bus.req0 = r0;
    bus.req1 = r1;
    @(posedge clk);
    model_edge(r0, r1);
    #1;
    check({tag, "_gnt0"},    int'(bus.gnt0),    int'(m_owner == 0));
    check({tag, "_gnt1"},    int'(bus.gnt1),    int'(m_owner == 1));
    check({tag, "_preempt"}, int'(bus.preempt), m_pre);
    check({tag, "_mutex"},   int'(bus.gnt0 & bus.gnt1), 0);
    check({tag, "_cause"},   int'((bus.gnt0 & ~r0) | (bus.gnt1 & ~r1)), 0);
  endtask

  int  pre_cnt, g0_cnt, g1_cnt, run0, run1, win;
  int  tie_exp[3];
  bit  rr0, rr1;

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    tie_exp[0] = 0; tie_exp[1] = 1; tie_exp[2] = 0;
`else
    tie_exp[0] = 0; tie_exp[1] = 0; tie_exp[2] = 0;
`endif
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    model_reset();

    // Reset state
    #12;
    check("rst_gnt0",    int'(bus.gnt0),    0);
    check("rst_gnt1",    int'(bus.gnt1),    0);
    check("rst_preempt", int'(bus.preempt), 0);
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-grant drops gnt0 without a clock edge
    step(1'b1, 1'b0, "pre_rst");
    step(1'b1, 1'b0, "pre_rst");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_async_gnt0",    int'(bus.gnt0),    0);
    check("rst_async_gnt1",    int'(bus.gnt1),    0);
    check("rst_async_preempt", int'(bus.preempt), 0);
    @(negedge clk);
    reset    = 1'b0;
    bus.req0 = 1'b0;
    step(1'b0, 1'b1, "rst_release");
    check("rst_release_g1", int'(bus.gnt1), 1);
    step(1'b0, 1'b0, "idle");
    step(1'b0, 1'b0, "idle");

    // Single requester holds indefinitely
    pre_cnt = 0; g0_cnt = 0; g1_cnt = 0;
    repeat (20) begin
      step(1'b1, 1'b0, "single");
      g0_cnt  += int'(bus.gnt0);
      g1_cnt  += int'(bus.gnt1);
      pre_cnt += int'(bus.preempt);
    end
    check("single_gnt0_cycles", g0_cnt, 20);
    check("single_gnt1_cycles", g1_cnt, 0);
    check("single_preempts",    pre_cnt, 0);
    step(1'b0, 1'b0, "idle");
    step(1'b0, 1'b0, "idle");

    // Pre-emption after MAX_HOLD cycles, then back again
    repeat (3) step(1'b1, 1'b0, "pre_hold");
    run0 = 3;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, "pre_wait");
      if (bus.gnt0) run0++;
      else break;
    end
    check("preempt_run0",  run0, MAX_HOLD);
    check("preempt_to1",   int'(bus.gnt1), 1);
    check("preempt_pulse", int'(bus.preempt), 1);
    run1 = 1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, "pre_back");
      if (bus.gnt1) run1++;
      else break;
    end
    check("preempt_run1",   run1, MAX_HOLD);
    check("preempt_back0",  int'(bus.gnt0), 1);
    check("preempt_pulse2", int'(bus.preempt), 1);
    step(1'b0, 1'b0, "idle");
    step(1'b0, 1'b0, "idle");

    // Handoff with no gap
    repeat (3) step(1'b1, 1'b0, "ho_hold");
    step(1'b0, 1'b1, "handoff");
    check("handoff_gnt1", int'(bus.gnt1), 1);
    check("handoff_gnt0", int'(bus.gnt0), 0);
    step(1'b0, 1'b0, "idle");

    // Drop and re-raise: one idle cycle then re-grant
    step(1'b1, 1'b0, "regrant");
    step(1'b0, 1'b0, "regrant_gap");
    check("regrant_gap_gnt0", int'(bus.gnt0), 0);
    step(1'b1, 1'b0, "regrant");
    check("regrant_gnt0", int'(bus.gnt0), 1);
    step(1'b0, 1'b0, "idle");

    // Ties from IDLE, starting from a fresh reset
    @(negedge clk);
    reset = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, "tie");
      win = bus.gnt1 ? 1 : 0;
      check($sformatf("tie_winner_%0d", k), win, tie_exp[k]);
      step(1'b1, 1'b1, "tie_hold");
      step(1'b0, 1'b0, "tie_drop");
    end

    // Random traffic with sticky requests so holds and pre-emption occur
    rr0 = 1'b0; rr1 = 1'b0;
    repeat (1000) begin
      if ($urandom_range(0, 3) == 0) rr0 = ~rr0;
      if ($urandom_range(0, 3) == 0) rr1 = ~rr1;
      step(rr0, rr1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
